// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched word and PC into the decode stage,
// with stall, flush and optional fetch-address checking (define IF_EXC_CHECK_EN).
module if_id_reg #(
    parameter logic [31:0] PC_LO = 32'h0000_3000,
    parameter logic [31:0] PC_HI = 32'h0000_4FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] instr_in,
    input  logic        PC_en,
    input  logic        Exception,
    input  logic        nPC_sel_eret,
    input  logic        D_is_jb,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        BD_D,
    output logic [4:0]  ExcCode_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_HELD
    } state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc8_q, pc8_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic        valid_q, valid_d;

    logic        flush;
    logic        fetch_adel;

    assign flush = Exception | nPC_sel_eret;

`ifdef IF_EXC_CHECK_EN
    assign fetch_adel = (PC[1:0] != 2'b00) || (PC < PC_LO) || (PC > PC_HI);
`else
    assign fetch_adel = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        valid_d = valid_q;

        if (flush) begin
            state_d = S_EMPTY;
            ir_d    = 32'd0;
            pc_d    = PC;
            pc8_d   = PC + 32'd8;
            bd_d    = 1'b0;
            exc_d   = EXC_NONE;
            valid_d = 1'b0;
        end else if (PC_en) begin
            state_d = S_FULL;
            ir_d    = fetch_adel ? 32'd0 : instr_in;
            pc_d    = PC;
            pc8_d   = PC + 32'd8;
            bd_d    = D_is_jb;
            exc_d   = fetch_adel ? EXC_ADEL : EXC_NONE;
            valid_d = 1'b1;
        end else if (state_q == S_FULL) begin
            state_d = S_HELD;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            state_q <= S_EMPTY;
            ir_q    <= 32'd0;
            pc_q    <= RESET_PC;
            pc8_q   <= RESET_PC + 32'd8;
            bd_q    <= 1'b0;
            exc_q   <= EXC_NONE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            valid_q <= valid_d;
        end
    end

    assign IR_D      = ir_q;
    assign PC_D      = pc_q;
    assign PC8_D     = pc8_q;
    assign BD_D      = bd_q;
    assign ExcCode_D = exc_q;
    assign valid_D   = valid_q;

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high.
REQ-004 SHALL have port: PC  in  32  fetch-stage PC from next-PC unit.
REQ-005 SHALL have port: instr_in  in  32  instruction memory word at PC.
REQ-006 SHALL have port: PC_en  in  1  1 = advance stage, 0 = stall (hold).
REQ-007 SHALL have port: Exception  in  1  flush request from CP0.
REQ-008 SHALL have port: nPC_sel_eret  in  1  flush request for eret.
REQ-009 SHALL have port: D_is_jb  in  1  instruction currently in D is a branch or jump.
REQ-010 SHALL have port: IR_D  out  32  decode-stage instruction.
REQ-011 SHALL have port: PC_D  out  32  decode-stage PC.
REQ-012 SHALL have port: PC8_D  out  32  PC_D+8, the link address.
REQ-013 SHALL have port: BD_D  out  1  the D instruction is in a delay slot.
REQ-014 SHALL have port: ExcCode_D  out  5  fetch exception code, 0 = none.
REQ-015 SHALL have port: valid_D  out  1  the D slot holds a real instruction.
REQ-016 SHALL have parameter: PC_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-017 SHALL have parameter: PC_HI, default 32'h0000_4FFC, highest legal fetch address.

Function
REQ-018 SHALL hold an internal state machine with three states: EMPTY (valid_D=0), FULL (valid, advancing) and HELD (valid, stalled).
REQ-019 SHALL apply per-edge priority: reset > flush (Exception | nPC_sel_eret) > PC_en=1 capture > hold.
REQ-020 SHALL, on a flush, load IR_D=0, PC_D=PC, PC8_D=PC+8, BD_D=0, ExcCode_D=0 and valid_D=0, and enter EMPTY; a flush overrides PC_en=0.
REQ-021 SHALL, on a capture, load IR_D=instr_in, PC_D=PC, PC8_D=PC+8, BD_D=D_is_jb (sampled same edge) and valid_D=1, and enter FULL.
REQ-022 SHALL, on a hold (PC_en=0, no flush), keep all outputs unchanged; FULL->HELD; HELD and EMPTY stay.
REQ-023 SHALL make HELD->FULL on the first capture edge, and make EMPTY->FULL on capture.
REQ-024 SHALL have a latency of exactly one clock edge from PC/instr_in to the D outputs; all outputs SHALL be registered.
REQ-025 SHALL compute PC8_D modulo 2^32 (PC=32'hFFFF_FFFC gives 32'h0000_0004).
REQ-026 SHALL, when D_is_jb=1 at the same edge as a flush, give BD_D=0 (the flush wins).

Reset
REQ-027 SHALL, on reset, load IR_D=0, PC_D=32'h0000_3000, PC8_D=32'h0000_3008, BD_D=0, ExcCode_D=0, valid_D=0, and the state EMPTY.
REQ-028 SHALL, on reset asserted mid-stall or mid-flush, override everything within the same edge; the stage SHALL capture on the first edge after reset with PC_en=1.

Configuration
REQ-029 SHALL use macro IF_EXC_CHECK_EN to compile fetch address checking in or out.
REQ-030 SHALL, when IF_EXC_CHECK_EN is defined, on capture with PC[1:0]!=0 or PC<PC_LO or PC>PC_HI, load ExcCode_D=5'd4 (AdEL) and IR_D=0, with valid_D=1 and PC_D=PC.
REQ-031 SHALL, when IF_EXC_CHECK_EN is undefined, keep ExcCode_D constant 0 and always capture IR_D=instr_in; the PC_LO and PC_HI parameters SHALL then be unused.

Verification
REQ-032 SHALL cover: reset, then PC=0x3000, instr_in=0x3C010001, PC_en=1, one edge -> IR_D=0x3C010001, PC_D=0x3000, PC8_D=0x3008, valid_D=1.
REQ-033 SHALL cover: PC_en=0 for 3 edges with instr_in changing -> IR_D and PC_D unchanged; then PC_en=1 -> new word captured next edge.
REQ-034 SHALL cover: D_is_jb=1 with capture of PC=0x3004 -> BD_D=1; next capture with D_is_jb=0 -> BD_D=0.
REQ-035 SHALL cover: Exception=1 with PC_en=0 and PC=0x4180 -> IR_D=0, valid_D=0, PC_D=0x4180, BD_D=0 after one edge.
REQ-036 SHALL cover, with IF_EXC_CHECK_EN defined: PC=0x3002 captured -> ExcCode_D=4, IR_D=0; PC=0x5000 -> ExcCode_D=4; with the macro undefined -> ExcCode_D=0 and IR_D=instr_in.
REQ-037 SHALL cover: reset and Exception both high with PC_en=1 -> reset values per REQ-027.
